pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the 5-stage core. It watches the ID-stage operand addresses, the EX-stage destination, the EX branch/jump result and data-memory busy. It drives the per-stage stall_flg inputs (IF/ID/EX), the bubble/flush controls and the fetch redirect. It owns the only pipeline-control FSM in the core; the stages only hold or clear their save registers as told.

---
 rtl/pipeline_hazard_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/redirect sequencer for the 5-stage core.
// Optional perf counters when PIPE_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        id_rs1_addr,
  input  logic [4:0]        id_rs2_addr,
  input  logic              id_rs1_used,
  input  logic              id_rs2_used,
  input  logic              ex_rf_wen,
  input  logic [4:0]        ex_wb_addr,
  input  logic              ex_is_load,
  input  logic              br_flg,
  input  logic              jmp_flg,
  input  logic [31:0]       br_target,
  input  logic              mem_busy,
  output logic              stall_if,
  output logic              stall_id,
  output logic              stall_ex,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles,
  output logic [CNT_W-1:0]  flush_events,
  output logic [CNT_W-1:0]  loaduse_events
`endif
);
  typedef enum logic [1:0] {RUN = 2'd0, MEMW = 2'd1, FLUSH = 2'd2} state_t;
  localparam logic [3:0] FC_M1 = 4'(FLUSH_CYCLES - 1);
  state_t state, state_nx;
  logic [3:0] cnt, cnt_nx;
  logic redir, lu, lu_act;
  assign redir = br_flg | jmp_flg;
  assign lu = ex_is_load & ex_rf_wen & (ex_wb_addr != 5'd0) &
              ((id_rs1_used & (id_rs1_addr == ex_wb_addr)) |
               (id_rs2_used & (id_rs2_addr == ex_wb_addr)));
  assign lu_act = !rst && state == RUN && !mem_busy && !redir && lu;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= RUN;
      cnt <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  always_comb begin
    state_nx = RUN;
    cnt_nx = cnt;
    case (state)
      RUN:
        if (mem_busy) state_nx = MEMW;
        else if (redir && FLUSH_CYCLES > 1) begin
          state_nx = FLUSH;
          cnt_nx = FC_M1;
        end
      MEMW: state_nx = mem_busy ? MEMW : RUN;
      FLUSH:
        if (mem_busy) state_nx = FLUSH;
        else begin
          cnt_nx = (cnt == 4'd0) ? cnt : cnt - 4'd1;
          state_nx = (cnt <= 4'd1) ? RUN : FLUSH;
        end
      default: state_nx = RUN;
    endcase
  end
  always_comb begin
    stall_if = 1'b0;
    stall_id = 1'b0;
    stall_ex = 1'b0;
    flush_id = 1'b0;
    flush_ex = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = rst ? 32'd0 : br_target;
    if (rst) begin
      flush_id = 1'b1;
      flush_ex = 1'b1;
    end else
      case (state)
        RUN:
          if (mem_busy) {stall_if, stall_id, stall_ex} = 3'b111;
          else if (redir) {redirect_valid, flush_id, flush_ex} = 3'b111;
          else if (lu) {stall_if, stall_id, flush_ex} = 3'b111;
        MEMW: {stall_if, stall_id, stall_ex} = {3{mem_busy}};
        FLUSH: begin
          flush_id = 1'b1;
          flush_ex = 1'b1;
          stall_if = mem_busy;
        end
        default: ;
      endcase
  end
`ifdef PIPE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      stall_cycles <= '0;
      flush_events <= '0;
      loaduse_events <= '0;
    end else begin
      if (stall_ex && ~&stall_cycles) stall_cycles <= stall_cycles + CNT_W'(1);
      if (redirect_valid && ~&flush_events) flush_events <= flush_events + CNT_W'(1);
      if (lu_act && ~&loaduse_events) loaduse_events <= loaduse_events + CNT_W'(1);
    end
`endif
endmodule
